ipsxb_qsgmii_lane_rst_fsm: RTL and testbench



---
 rtl/ipsxb_qsgmii_lane_rst_fsm.sv | 129 ++++++++++++
 tb/tb_ipsxb_qsgmii_lane_rst_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxb_qsgmii_lane_rst_fsm.sv
// ipsxb_qsgmii_lane_rst_fsm: QSGMII HSST lane bring-up sequencer (PLL, TX lane, RX lane resets)
// Ports:
//   clk, rst_n              free-running config clock, async active-low reset
//   i_pll_lock/i_rx_sigdet/i_cdr_lock  async HSST status, 2-flop synchronised here
//   i_force_rst             level request to hold and restart the whole sequence
//   o_pll_rst/o_tx_lane_rst/o_rx_lane_rst  active-high resets
//   o_tx_lane_done/o_rx_lane_done  lane ready levels for the PCS reset generator
//   o_retry_cnt             saturating timeout retry count (TX and RX combined)
module ipsxb_qsgmii_lane_rst_fsm #(
  parameter int CNT_W        = 20,
  parameter int RST_HOLD     = 64,
  parameter int LOCK_STABLE  = 1024,
  parameter int CDR_STABLE   = 1024,
  parameter int LOCK_TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pll_lock,
  input  logic       i_rx_sigdet,
  input  logic       i_cdr_lock,
  input  logic       i_force_rst,
  output logic       o_pll_rst,
  output logic       o_tx_lane_rst,
  output logic       o_rx_lane_rst,
  output logic       o_tx_lane_done,
  output logic       o_rx_lane_done,
  output logic [7:0] o_retry_cnt
);
  typedef enum logic [1:0] {TX_PLL_RST, TX_WAIT_LOCK, TX_LANE_RST, TX_DONE} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_WAIT_SIGDET, RX_LANE_RST, RX_WAIT_CDR, RX_DONE} rx_state_t;
  // Counters compare against N-1 so a state lasts exactly N cycles from entry.
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CDR_END  = CNT_W'(CDR_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(LOCK_TIMEOUT - 1);
  logic [1:0] r_lock_s, r_sig_s, r_cdr_s;
  logic w_lock, w_sig, w_cdr;
  tx_state_t r_tx_st, w_tx_nxt;
  rx_state_t r_rx_st, w_rx_nxt;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt, r_tx_to, w_tx_to_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt, r_rx_to, w_rx_to_nxt;
  logic w_tx_tmo, w_rx_tmo;
  assign w_lock = r_lock_s[1];
  assign w_sig  = r_sig_s[1];
  assign w_cdr  = r_cdr_s[1];
  always_comb begin
    w_tx_nxt     = r_tx_st;
    w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
    w_tx_to_nxt  = '0;
    w_tx_tmo     = 1'b0;
    if (i_force_rst) w_tx_nxt = TX_PLL_RST;
    else case (r_tx_st)
      TX_PLL_RST:   w_tx_nxt = (r_tx_cnt == HOLD_END) ? TX_WAIT_LOCK : TX_PLL_RST;
      TX_WAIT_LOCK: begin
        w_tx_cnt_nxt = w_lock ? r_tx_cnt + CNT_W'(1) : '0;
        w_tx_to_nxt  = r_tx_to + CNT_W'(1);
        // Reaching stability wins over a timeout landing on the same cycle.
        w_tx_tmo     = !(w_lock && r_tx_cnt == LOCK_END) && r_tx_to == TMO_END;
        w_tx_nxt     = (w_lock && r_tx_cnt == LOCK_END) ? TX_LANE_RST : w_tx_tmo ? TX_PLL_RST : TX_WAIT_LOCK;
      end
      TX_LANE_RST:  w_tx_nxt = !w_lock ? TX_PLL_RST : (r_tx_cnt == HOLD_END) ? TX_DONE : TX_LANE_RST;
      default:      w_tx_nxt = w_lock ? TX_DONE : TX_PLL_RST;
    endcase
    if (i_force_rst || w_tx_nxt != r_tx_st || w_tx_nxt == TX_DONE) begin
      w_tx_cnt_nxt = '0;
      w_tx_to_nxt  = '0;
    end
  end
  always_comb begin
    w_rx_nxt     = r_rx_st;
    w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
    w_rx_to_nxt  = '0;
    w_rx_tmo     = 1'b0;
    // RX only advances while TX is done and staying done; any TX exit parks RX in the same cycle.
    if (r_tx_st != TX_DONE || w_tx_nxt != TX_DONE) w_rx_nxt = RX_IDLE;
    else case (r_rx_st)
      RX_IDLE:        w_rx_nxt = RX_WAIT_SIGDET;
      RX_WAIT_SIGDET: w_rx_nxt = w_sig ? RX_LANE_RST : RX_WAIT_SIGDET;
      RX_LANE_RST:    w_rx_nxt = (r_rx_cnt == HOLD_END) ? RX_WAIT_CDR : RX_LANE_RST;
      RX_WAIT_CDR: begin
        w_rx_cnt_nxt = w_cdr ? r_rx_cnt + CNT_W'(1) : '0;
        w_rx_to_nxt  = r_rx_to + CNT_W'(1);
        w_rx_tmo     = w_sig && !(w_cdr && r_rx_cnt == CDR_END) && r_rx_to == TMO_END;
        w_rx_nxt     = !w_sig ? RX_WAIT_SIGDET : (w_cdr && r_rx_cnt == CDR_END) ? RX_DONE : w_rx_tmo ? RX_LANE_RST : RX_WAIT_CDR;
      end
      default:        w_rx_nxt = (w_sig && w_cdr) ? RX_DONE : RX_WAIT_SIGDET;
    endcase
    if (w_rx_nxt != r_rx_st || (w_rx_nxt != RX_LANE_RST && w_rx_nxt != RX_WAIT_CDR)) begin
      w_rx_cnt_nxt = '0;
      w_rx_to_nxt  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s       <= '0;
      r_sig_s        <= '0;
      r_cdr_s        <= '0;
      r_tx_st        <= TX_PLL_RST;
      r_rx_st        <= RX_IDLE;
      r_tx_cnt       <= '0;
      r_tx_to        <= '0;
      r_rx_cnt       <= '0;
      r_rx_to        <= '0;
      o_pll_rst      <= 1'b1;
      o_tx_lane_rst  <= 1'b1;
      o_rx_lane_rst  <= 1'b1;
      o_tx_lane_done <= 1'b0;
      o_rx_lane_done <= 1'b0;
      o_retry_cnt    <= '0;
    end else begin
      r_lock_s       <= {r_lock_s[0], i_pll_lock};
      r_sig_s        <= {r_sig_s[0], i_rx_sigdet};
      r_cdr_s        <= {r_cdr_s[0], i_cdr_lock};
      r_tx_st        <= w_tx_nxt;
      r_rx_st        <= w_rx_nxt;
      r_tx_cnt       <= w_tx_cnt_nxt;
      r_tx_to        <= w_tx_to_nxt;
      r_rx_cnt       <= w_rx_cnt_nxt;
      r_rx_to        <= w_rx_to_nxt;
      // Outputs are decoded from the next state so they change on the same edge as the state.
      o_pll_rst      <= w_tx_nxt == TX_PLL_RST;
      o_tx_lane_rst  <= w_tx_nxt != TX_DONE;
      o_tx_lane_done <= w_tx_nxt == TX_DONE;
      o_rx_lane_rst  <= w_rx_nxt != RX_WAIT_CDR && w_rx_nxt != RX_DONE;
      o_rx_lane_done <= w_rx_nxt == RX_DONE;
      o_retry_cnt    <= ((w_tx_tmo || w_rx_tmo) && o_retry_cnt != 8'hff) ? o_retry_cnt + 8'd1 : o_retry_cnt;
    end
  end
endmodule

// File: tb/tb_ipsxb_qsgmii_lane_rst_fsm.sv
// tb_ipsxb_qsgmii_lane_rst_fsm: scenario and randomized checks of the lane bring-up sequencer
module tb_ipsxb_qsgmii_lane_rst_fsm;
  localparam int HOLD = 4, LS = 8, CS = 8, TMO = 100;
  localparam int P_PLL = 0, P_WAIT = 1, P_LRST = 2, P_DONE = 3;
  localparam int R_IDLE = 0, R_SIG = 1, R_LRST = 2, R_CDR = 3, R_DONE = 4;
  localparam logic [12:0] RST_V = {3'b111, 2'b00, 8'd0};
  logic clk = 0, rst_n = 1, lock = 0, sig = 0, cdr = 0, force_rst = 0;
  logic o_pll_rst, o_tx_lane_rst, o_rx_lane_rst, o_tx_lane_done, o_rx_lane_done;
  logic [7:0] o_retry_cnt;
  logic [12:0] dv;
  int checks = 0, failures = 0;
  int tph, tt, rph, rt, lrun, crun, retry;
  logic ml, sl, ms, ss, mc, sc;
  always #5 clk = ~clk;
  assign dv = {o_pll_rst, o_tx_lane_rst, o_rx_lane_rst, o_tx_lane_done, o_rx_lane_done, o_retry_cnt};
  ipsxb_qsgmii_lane_rst_fsm #(.CNT_W(20), .RST_HOLD(HOLD), .LOCK_STABLE(LS), .CDR_STABLE(CS), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .i_pll_lock(lock), .i_rx_sigdet(sig), .i_cdr_lock(cdr), .i_force_rst(force_rst),
    .o_pll_rst(o_pll_rst), .o_tx_lane_rst(o_tx_lane_rst), .o_rx_lane_rst(o_rx_lane_rst),
    .o_tx_lane_done(o_tx_lane_done), .o_rx_lane_done(o_rx_lane_done), .o_retry_cnt(o_retry_cnt));
  function automatic int mn(int a, int b);
    return a < b ? a : b;
  endfunction
  function automatic void m_reset();
    tph = P_PLL; tt = 0; rph = R_IDLE; rt = 0; lrun = 0; crun = 0; retry = 0;
    ml = 0; sl = 0; ms = 0; ss = 0; mc = 0; sc = 0;
  endfunction
  // Phase model: tt/rt = cycles already spent in the phase, lrun/crun = length of the current
  // synchronised high run; a stable wait completes once the run inside the phase reaches the target.
  function automatic void m_step();
    int nt, nr;
    bit tmo;
    lrun = sl ? lrun + 1 : 0;
    crun = sc ? crun + 1 : 0;
    tmo = 0;
    nt = tph;
    if (force_rst) nt = P_PLL;
    else if (tph == P_PLL) nt = (tt + 1 >= HOLD) ? P_WAIT : P_PLL;
    else if (tph == P_WAIT) begin
      if (sl && mn(lrun, tt + 1) >= LS) nt = P_LRST;
      else if (tt + 1 >= TMO) begin nt = P_PLL; tmo = 1; end
    end else if (tph == P_LRST) nt = !sl ? P_PLL : (tt + 1 >= HOLD) ? P_DONE : P_LRST;
    else nt = sl ? P_DONE : P_PLL;
    nr = rph;
    if (tph != P_DONE || nt != P_DONE) nr = R_IDLE;
    else if (rph == R_IDLE) nr = R_SIG;
    else if (rph == R_SIG) nr = ss ? R_LRST : R_SIG;
    else if (rph == R_LRST) nr = (rt + 1 >= HOLD) ? R_CDR : R_LRST;
    else if (rph == R_CDR) begin
      if (!ss) nr = R_SIG;
      else if (sc && mn(crun, rt + 1) >= CS) nr = R_DONE;
      else if (rt + 1 >= TMO) begin nr = R_LRST; tmo = 1; end
    end else nr = (ss && sc) ? R_DONE : R_SIG;
    if (tmo && retry < 255) retry++;
    tt = (nt == tph && !force_rst) ? tt + 1 : 0;
    rt = (nr == rph) ? rt + 1 : 0;
    tph = nt; rph = nr;
    sl = ml; ml = lock; ss = ms; ms = sig; sc = mc; mc = cdr;
  endfunction
  function automatic logic [12:0] m_out();
    return {tph == P_PLL, tph != P_DONE, rph <= R_LRST, tph == P_DONE, rph == R_DONE, 8'(retry)};
  endfunction
  task automatic tick();
    @(posedge clk);
    if (rst_n) m_step(); else m_reset();
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    #1 rst_n = 0;
    m_reset();
    @(negedge clk);
    checks++;
    if (dv !== RST_V) begin failures++; $display("FAIL reset_now got=%h exp=%h", dv, RST_V); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dv !== RST_V) begin failures++; $display("FAIL reset_hold got=%h exp=%h", dv, RST_V); end
  endtask
  task automatic test_bringup();
    int tp, td, rd;
    lock = 1; sig = 1; cdr = 1; force_rst = 0;
    do_reset();
    tp = 0; td = 0; rd = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL bringup cyc=%0d got=%h exp=%h", i, dv, m_out()); end
      if (tp == 0 && !o_pll_rst) tp = i;
      if (td == 0 && o_tx_lane_done) td = i;
      if (rd == 0 && o_rx_lane_done) rd = i;
    end
    checks++;
    if (tp != 4) begin failures++; $display("FAIL bringup_pll_fall got=%0d exp=4", tp); end
    checks++;
    if (td != 16) begin failures++; $display("FAIL bringup_tx_done got=%0d exp=16", td); end
    checks++;
    if (rd != 30) begin failures++; $display("FAIL bringup_rx_done got=%0d exp=30", rd); end
    checks++;
    if (o_retry_cnt !== 8'd0) begin failures++; $display("FAIL bringup_retry got=%0d exp=0", o_retry_cnt); end
  endtask
  task automatic test_lock_glitch();
    int td, dt, dr, pr;
    lock = 1; sig = 1; cdr = 1;
    do_reset();
    td = 0; dt = 0; dr = 0; pr = 0;
    for (int i = 1; i <= 70; i++) begin
      lock = !(i == 10 || i == 50);
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL glitch cyc=%0d got=%h exp=%h", i, dv, m_out()); end
      if (td == 0 && o_tx_lane_done) td = i;
      if (i > 40 && dt == 0 && !o_tx_lane_done) begin dt = i; pr = o_pll_rst; end
      if (i > 40 && dr == 0 && !o_rx_lane_done) dr = i;
    end
    checks++;
    if (td != 24) begin failures++; $display("FAIL glitch_wait_tx_done got=%0d exp=24", td); end
    checks++;
    if (dt != 52 || dr != 52) begin failures++; $display("FAIL glitch_done_drop got=%0d/%0d exp=52/52", dt, dr); end
    checks++;
    if (pr != 1) begin failures++; $display("FAIL glitch_pll_rst got=%0d exp=1", pr); end
  endtask
  task automatic test_sigdet();
    int anyrx, rf, rd;
    lock = 1; sig = 0; cdr = 1;
    do_reset();
    anyrx = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL nosig cyc=%0d got=%h exp=%h", i, dv, m_out()); end
      if (o_rx_lane_done) anyrx = 1;
    end
    checks++;
    if (anyrx != 0 || o_tx_lane_done !== 1'b1 || o_retry_cnt !== 8'd0) begin
      failures++; $display("FAIL nosig_hold got=rx%0d/tx%0d/retry%0d exp=rx0/tx1/retry0", anyrx, o_tx_lane_done, o_retry_cnt);
    end
    sig = 1;
    rf = 0; rd = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL sigrise cyc=%0d got=%h exp=%h", i, dv, m_out()); end
      if (rf == 0 && !o_rx_lane_rst) rf = i;
      if (rd == 0 && o_rx_lane_done) rd = i;
    end
    checks++;
    if (rf != 7 || rd != 15) begin failures++; $display("FAIL sigrise_timing got=%0d/%0d exp=7/15", rf, rd); end
  endtask
  task automatic test_cdr_never();
    int lost, rises;
    logic prev;
    lock = 1; sig = 1; cdr = 0;
    do_reset();
    lost = 0; rises = 0; prev = 1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL nocdr cyc=%0d got=%h exp=%h", i, dv, m_out()); end
      if (i > 16 && !o_tx_lane_done) lost++;
      if (i > 30 && o_rx_lane_rst && !prev) rises++;
      prev = o_rx_lane_rst;
    end
    checks++;
    if (o_retry_cnt !== 8'd3 || rises != 3 || lost != 0) begin
      failures++; $display("FAIL nocdr_retry got=retry%0d/rises%0d/lost%0d exp=retry3/rises3/lost0", o_retry_cnt, rises, lost);
    end
  endtask
  task automatic test_force();
    int td, rd;
    lock = 1; sig = 1; cdr = 1;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL force_pre cyc=%0d got=%h exp=%h", i, dv, m_out()); end
    end
    force_rst = 1;
    tick();
    checks++;
    if (dv !== RST_V) begin failures++; $display("FAIL force_edge got=%h exp=%h", dv, RST_V); end
    tick();
    tick();
    force_rst = 0;
    td = 0; rd = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL force_post cyc=%0d got=%h exp=%h", i, dv, m_out()); end
      if (td == 0 && o_tx_lane_done) td = i;
      if (rd == 0 && o_rx_lane_done) rd = i;
    end
    checks++;
    if (td != 16 || rd != 30) begin failures++; $display("FAIL force_rerun got=%0d/%0d exp=16/30", td, rd); end
  endtask
  task automatic test_rst_mid_cdr();
    int td, rd;
    lock = 1; sig = 1; cdr = 0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL rstcdr_pre cyc=%0d got=%h exp=%h", i, dv, m_out()); end
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (dv !== RST_V) begin failures++; $display("FAIL rstcdr_async got=%h exp=%h", dv, RST_V); end
    cdr = 1;
    @(negedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1;
    td = 0; rd = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL rstcdr_post cyc=%0d got=%h exp=%h", i, dv, m_out()); end
      if (td == 0 && o_tx_lane_done) td = i;
      if (rd == 0 && o_rx_lane_done) rd = i;
    end
    checks++;
    if (td != 16 || rd != 30) begin failures++; $display("FAIL rstcdr_rerun got=%0d/%0d exp=16/30", td, rd); end
  endtask
  task automatic test_random();
    int bad;
    lock = 1; sig = 1; cdr = 1;
    do_reset();
    bad = 0;
    for (int i = 1; i <= 4000; i++) begin
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      if ($urandom_range(0, 59) == 0) sig = ~sig;
      if ($urandom_range(0, 29) == 0) cdr = ~cdr;
      force_rst = ($urandom_range(0, 399) == 0);
      tick();
      checks++;
      if (dv !== m_out()) begin
        failures++;
        if (bad < 10) $display("FAIL random cyc=%0d got=%h exp=%h", i, dv, m_out());
        bad++;
      end
    end
    force_rst = 0;
  endtask
  task automatic test_saturation();
    int r1, r2;
    lock = 0; sig = 1; cdr = 1;
    do_reset();
    r1 = -1; r2 = -1;
    for (int i = 1; i <= 26600; i++) begin
      tick();
      checks++;
      if (dv !== m_out()) begin failures++; $display("FAIL nolock cyc=%0d got=%h exp=%h", i, dv, m_out()); end
      if (i == 104) r1 = o_retry_cnt;
      if (i == 208) r2 = o_retry_cnt;
    end
    checks++;
    if (r1 != 1 || r2 != 2) begin failures++; $display("FAIL nolock_period got=%0d/%0d exp=1/2", r1, r2); end
    checks++;
    if (o_retry_cnt !== 8'd255) begin failures++; $display("FAIL nolock_saturate got=%0d exp=255", o_retry_cnt); end
    do_reset();
    tick();
    checks++;
    if (o_retry_cnt !== 8'd0) begin failures++; $display("FAIL retry_clear got=%0d exp=0", o_retry_cnt); end
  endtask
  initial begin
    test_reset();
    test_bringup();
    test_lock_glitch();
    test_sigdet();
    test_cdr_never();
    test_force();
    test_rst_mid_cdr();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
